iq_freelist_ctrl: RTL and testbench

- Controller for the issue-queue free-entry list RAM.
- The list RAM is organised as a circular FIFO of free IQ entry indices.
- The block owns the head/tail pointers and the free count, and allocates up to DISPATCH_WIDTH entries per cycle to dispatch. It pushes up to FREE_WIDTH freed entries per cycle.
- It runs the post-reset/flush initialisation sequence that rewrites the RAM with the sequence 0..DEPTH-1.

---
 rtl/iq_freelist_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_iq_freelist_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_freelist_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// iq_freelist_ctrl
//
// Controller for the issue-queue free-entry list. The list RAM is kept
// outside this block and behaves as a circular FIFO of free IQ entry indices.
// This block owns the head pointer (allocation side), the tail pointer
// (freeing side) and the free count.
//
// After reset or flush the block rewrites the RAM with 0..DEPTH-1, using
// FREE_WIDTH entries per cycle. While it does this it refuses all
// allocations.
//
// Ports
//   clk            clock; all state changes on the rising edge
//   reset          asynchronous, active-low reset
//   flush_i        rebuild the list with all DEPTH entries free
//   dispatchReq_i  per-lane allocation request; set bits are contiguous
//                  from lane 0
//   freeVld_i      per-lane free valid (any mask)
//   freeEntry_i    entry index freed on each lane
//   rdAddr_o       list RAM read address per dispatch lane (head+k)
//   rdData_i       list RAM read data (combinational read)
//   wrAddr_o       list RAM write address per write lane
//   wrData_o       list RAM write data per write lane
//   wrEn_o         list RAM write enable per write lane
//   grantVld_o     allocation granted this cycle
//   grantIdx_o     allocated entries; lane k is meaningful when
//                  dispatchReq_i[k] is set
//   stall_o        allocation refused this cycle
//   freeCnt_o      registered free count (0..DEPTH)
//   ready_o        list initialised and usable
//   error_o        sticky free-overflow flag; cleared only by reset
// ---------------------------------------------------------------------------
module iq_freelist_ctrl #(
    parameter int DEPTH          = 32,
    parameter int INDEX          = 5,
    parameter int DISPATCH_WIDTH = 4,
    parameter int FREE_WIDTH     = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush_i,
    input  logic [DISPATCH_WIDTH-1:0]          dispatchReq_i,
    input  logic [FREE_WIDTH-1:0]              freeVld_i,
    input  logic [FREE_WIDTH*INDEX-1:0]        freeEntry_i,
    output logic [DISPATCH_WIDTH*INDEX-1:0]    rdAddr_o,
    input  logic [DISPATCH_WIDTH*INDEX-1:0]    rdData_i,
    output logic [FREE_WIDTH*INDEX-1:0]        wrAddr_o,
    output logic [FREE_WIDTH*INDEX-1:0]        wrData_o,
    output logic [FREE_WIDTH-1:0]              wrEn_o,
    output logic                               grantVld_o,
    output logic [DISPATCH_WIDTH*INDEX-1:0]    grantIdx_o,
    output logic                               stall_o,
    output logic [INDEX:0]                     freeCnt_o,
    output logic                               ready_o,
    output logic                               error_o
);

    // Count width covers 0..DEPTH. Sum width holds count + m before the
    // overflow test, so a value above DEPTH cannot wrap.
    localparam int CW = INDEX + 1;
    localparam int SW = INDEX + 2;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [INDEX-1:0]    head_reg, head_next;
    logic [INDEX-1:0]    tail_reg, tail_next;
    logic [INDEX-1:0]    init_ptr_reg, init_ptr_next;
    logic [CW-1:0]       count_reg, count_next;
    logic                error_reg, error_next;

    logic [CW-1:0]                   req_n;
    logic [CW-1:0]                   free_prefix [FREE_WIDTH+1];
    logic [CW-1:0]                   free_m;
    logic                            alloc_ok;
    logic                            alloc_short;
    logic [CW-1:0]                   granted_n;
    logic [CW-1:0]                   count_after_alloc;
    logic [SW-1:0]                   count_sum;
    logic                            overflow;
    logic                            init_last;
    logic [FREE_WIDTH*INDEX-1:0]     init_addr;
    logic [FREE_WIDTH*INDEX-1:0]     cmp_addr;
    logic [FREE_WIDTH*INDEX-1:0]     cmp_data;
    logic [FREE_WIDTH-1:0]           cmp_en;
    logic [DISPATCH_WIDTH*INDEX-1:0] grant_idx_lane;

    // -----------------------------------------------------------------------
    // Per-lane address generation
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_rd_lane
            // Read addresses are always presented, so the RAM data is
            // available in the same cycle the request arrives.
            assign rdAddr_o[gi*INDEX +: INDEX] = head_reg + INDEX'(gi);
            assign grant_idx_lane[gi*INDEX +: INDEX] =
                dispatchReq_i[gi] ? rdData_i[gi*INDEX +: INDEX] : '0;
        end

        for (genvar gi = 0; gi < FREE_WIDTH; gi++) begin : g_wr_lane
            assign init_addr[gi*INDEX +: INDEX] = init_ptr_reg + INDEX'(gi);
            assign cmp_addr[gi*INDEX +: INDEX]  = tail_reg + INDEX'(gi);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Lane counts
    // -----------------------------------------------------------------------
    always_comb begin
        req_n = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            req_n = req_n + CW'(dispatchReq_i[i]);
        end
    end

    // free_prefix[i] is the number of valid free lanes below lane i. That is
    // the write slot that lane i lands in once the valid lanes are packed.
    always_comb begin
        free_prefix[0] = '0;
        for (int i = 0; i < FREE_WIDTH; i++) begin
            free_prefix[i+1] = free_prefix[i] + CW'(freeVld_i[i]);
        end
    end

    assign free_m = free_prefix[FREE_WIDTH];

    // Pack the valid free lanes into write lanes 0..m-1, keeping lane order.
    always_comb begin
        cmp_en   = '0;
        cmp_data = '0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            for (int i = 0; i < FREE_WIDTH; i++) begin
                if (freeVld_i[i] && (free_prefix[i] == CW'(j))) begin
                    cmp_en[j]                  = 1'b1;
                    cmp_data[j*INDEX +: INDEX] = freeEntry_i[i*INDEX +: INDEX];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Allocation / overflow decisions
    // -----------------------------------------------------------------------
    // Allocation is all-or-nothing against the registered count. Frees from
    // the same cycle are not counted here, so there is no read-after-write
    // path through the RAM.
    assign alloc_ok    = (state_reg == ST_READY) && !flush_i &&
                         (req_n != '0) && (req_n <= count_reg);
    assign alloc_short = (req_n > count_reg);
    assign granted_n   = alloc_ok ? req_n : '0;

    assign count_after_alloc = count_reg - granted_n;
    assign count_sum         = SW'(count_after_alloc) + SW'(free_m);
    assign overflow          = (count_sum > SW'(DEPTH));

    assign init_last = (init_ptr_reg == INDEX'(DEPTH - FREE_WIDTH));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_INIT;
            head_reg     <= '0;
            tail_reg     <= '0;
            init_ptr_reg <= '0;
            count_reg    <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            init_ptr_reg <= init_ptr_next;
            count_reg    <= count_next;
            error_reg    <= error_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        init_ptr_next = init_ptr_reg;
        count_next    = count_reg;
        error_next    = error_reg;

        case (state_reg)
            ST_INIT: begin
                if (flush_i) begin
                    // Start the rewrite again from entry 0.
                    init_ptr_next = '0;
                    count_next    = '0;
                end else if (init_last) begin
                    state_next    = ST_READY;
                    init_ptr_next = '0;
                    head_next     = '0;
                    tail_next     = '0;
                    count_next    = CW'(DEPTH);
                end else begin
                    init_ptr_next = init_ptr_reg + INDEX'(FREE_WIDTH);
                end
            end

            ST_READY: begin
                if (flush_i) begin
                    // Flush has priority. Any dispatch or free in this
                    // cycle is dropped, because the list is rebuilt anyway.
                    state_next    = ST_INIT;
                    init_ptr_next = '0;
                    head_next     = '0;
                    tail_next     = '0;
                    count_next    = '0;
                end else begin
                    head_next = head_reg + granted_n[INDEX-1:0];
                    if (overflow) begin
                        // More frees than the list can hold means a caller
                        // has freed something twice. Keep the list
                        // consistent by dropping every free in this cycle.
                        error_next = 1'b1;
                        count_next = count_after_alloc;
                    end else begin
                        tail_next  = tail_reg + free_m[INDEX-1:0];
                        count_next = count_sum[CW-1:0];
                    end
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        grantVld_o = 1'b0;
        grantIdx_o = '0;
        stall_o    = 1'b0;
        wrEn_o     = '0;
        wrAddr_o   = cmp_addr;
        wrData_o   = cmp_data;

        case (state_reg)
            ST_INIT: begin
                stall_o  = 1'b1;
                wrAddr_o = init_addr;
                wrData_o = init_addr;
                // The state already reads INIT while reset is held, so the
                // enables are gated to keep the RAM untouched during reset.
                wrEn_o   = {FREE_WIDTH{reset}};
            end

            ST_READY: begin
                if (flush_i) begin
                    stall_o = 1'b1;
                end else begin
                    grantVld_o = alloc_ok;
                    stall_o    = alloc_short;
                    grantIdx_o = alloc_ok ? grant_idx_lane : '0;
                    wrEn_o     = overflow ? '0 : cmp_en;
                end
            end
        endcase
    end

    assign freeCnt_o = count_reg;
    assign ready_o   = (state_reg == ST_READY);
    assign error_o   = error_reg;

endmodule

// File: tb/tb_iq_freelist_ctrl.sv
`timescale 1ns/1ps
// Testbench for iq_freelist_ctrl. The list RAM is modelled here as an array.
// Free entries are tracked as an ordered queue of indices.
module tb_iq_freelist_ctrl;

    localparam int DEPTH = 32;
    localparam int INDEX = 5;
    localparam int DW    = 4;
    localparam int FW    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush_i;
    logic [DW-1:0]       dispatchReq_i;
    logic [FW-1:0]       freeVld_i;
    logic [FW*INDEX-1:0] freeEntry_i;
    logic [DW*INDEX-1:0] rdAddr_o;
    logic [DW*INDEX-1:0] rdData_i;
    logic [FW*INDEX-1:0] wrAddr_o;
    logic [FW*INDEX-1:0] wrData_o;
    logic [FW-1:0]       wrEn_o;
    logic                grantVld_o;
    logic [DW*INDEX-1:0] grantIdx_o;
    logic                stall_o;
    logic [INDEX:0]      freeCnt_o;
    logic                ready_o;
    logic                error_o;

    always #5 clk = ~clk;

    iq_freelist_ctrl #(
        .DEPTH(DEPTH), .INDEX(INDEX), .DISPATCH_WIDTH(DW), .FREE_WIDTH(FW)
    ) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .dispatchReq_i(dispatchReq_i), .freeVld_i(freeVld_i),
        .freeEntry_i(freeEntry_i), .rdAddr_o(rdAddr_o), .rdData_i(rdData_i),
        .wrAddr_o(wrAddr_o), .wrData_o(wrData_o), .wrEn_o(wrEn_o),
        .grantVld_o(grantVld_o), .grantIdx_o(grantIdx_o), .stall_o(stall_o),
        .freeCnt_o(freeCnt_o), .ready_o(ready_o), .error_o(error_o)
    );

    // List RAM: synchronous write, combinational read.
    logic [INDEX-1:0] ram [DEPTH];
    always @(posedge clk) begin
        for (int k = 0; k < FW; k++)
            if (wrEn_o[k]) ram[wrAddr_o[k*INDEX +: INDEX]] <= wrData_o[k*INDEX +: INDEX];
    end
    always_comb begin
        rdData_i = '0;
        for (int k = 0; k < DW; k++)
            rdData_i[k*INDEX +: INDEX] = ram[rdAddr_o[k*INDEX +: INDEX]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [19:0] rdp(input int h);
        return pk(h % DEPTH, (h + 1) % DEPTH, (h + 2) % DEPTH, (h + 3) % DEPTH);
    endfunction

    function automatic logic [19:0] lmask(input logic [3:0] b);
        logic [19:0] r = '0;
        for (int k = 0; k < 4; k++) if (b[k]) r[k*5 +: 5] = 5'h1f;
        return r;
    endfunction

    // ---------------- reference model: ordered free list ----------------
    int free_q[$];
    bit alloc_bits[DEPTH];
    bit m_err;

    task automatic model_reset_list();
        free_q.delete();
        for (int e = 0; e < DEPTH; e++) begin
            free_q.push_back(e);
            alloc_bits[e] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] req, input logic [3:0] fvld,
                              input logic [19:0] fent, output bit gv, output bit st,
                              output logic [19:0] idx, output logic [3:0] wren);
        int n, m, e;
        n   = $countones(req);
        m   = $countones(fvld);
        gv  = (n > 0) && (n <= free_q.size());
        st  = (n > free_q.size());
        idx = '0;
        if (gv) begin
            for (int k = 0; k < n; k++) begin
                e = free_q.pop_front();
                idx[k*5 +: 5] = 5'(e);
                alloc_bits[e] = 1'b1;
            end
        end
        if (free_q.size() + m > DEPTH) begin
            m_err = 1'b1;
            wren  = '0;
        end else begin
            wren = 4'((1 << m) - 1);
            for (int k = 0; k < 4; k++) begin
                if (fvld[k]) begin
                    e = int'(fent[k*5 +: 5]);
                    free_q.push_back(e);
                    alloc_bits[e] = 1'b0;
                end
            end
        end
    endtask

    // One model-checked cycle. Call it 1 ns after a rising edge.
    task automatic mcycle(input logic [3:0] req, input logic [3:0] fvld,
                          input logic [19:0] fent, input string tag);
        bit gv, st;
        logic [19:0] idx;
        logic [3:0] wren;
        dispatchReq_i = req;
        freeVld_i     = fvld;
        freeEntry_i   = fent;
        model_step(req, fvld, fent, gv, st, idx, wren);
        @(negedge clk);
        check({tag, ".grantVld"}, grantVld_o, gv);
        check({tag, ".stall"}, stall_o, st);
        if (gv) check({tag, ".grantIdx"}, grantIdx_o & lmask(req), idx & lmask(req));
        check({tag, ".wrEn"}, wrEn_o, wren);
        @(posedge clk); #1;
        check({tag, ".freeCnt"}, freeCnt_o, free_q.size());
        check({tag, ".error"}, error_o, m_err);
        $display("%s req=%b fvld=%b gv=%0d cnt=%0d", tag, req, fvld, grantVld_o, freeCnt_o);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  req;
        logic [3:0]  fvld;
        logic [19:0] fent;
        bit          gv;
        bit          st;
        int          head;
        logic [19:0] idx;
        logic [3:0]  wren;
        logic [19:0] wa;
        logic [19:0] wd;
        int          cnt;
        bit          err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] fvld,
                                input logic [19:0] fent, input bit gv, input bit st,
                                input int head, input logic [19:0] idx,
                                input logic [3:0] wren, input logic [19:0] wa,
                                input logic [19:0] wd, input int cnt, input bit err);
        vec_t v;
        v.req = req; v.fvld = fvld; v.fent = fent; v.gv = gv; v.st = st;
        v.head = head; v.idx = idx; v.wren = wren; v.wa = wa; v.wd = wd;
        v.cnt = cnt; v.err = err;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int h, e;
        bit gv_d, st_d;
        logic [19:0] idx_d;
        logic [3:0] wren_d;

        // Table: starts right after init (list 0..31, head=tail=0, count=32).
        vt.push_back(mk(4'b0111, 4'b0000, 0, 1, 0, 0, pk(0,1,2,0), 4'b0000, 0, 0, 29, 0));
        vt.push_back(mk(4'b1111, 4'b0000, 0, 1, 0, 3, pk(3,4,5,6), 4'b0000, 0, 0, 25, 0));
        vt.push_back(mk(4'b0000, 4'b0101, pk(2,0,0,0), 0, 0, 7, 0, 4'b0011, pk(0,1,0,0), pk(2,0,0,0), 27, 0));
        vt.push_back(mk(4'b0001, 4'b1000, pk(0,0,0,5), 1, 0, 7, pk(7,0,0,0), 4'b0001, pk(2,0,0,0), pk(5,0,0,0), 27, 0));
        vt.push_back(mk(4'b0011, 4'b1111, pk(1,3,4,6), 1, 0, 8, pk(8,9,0,0), 4'b1111, pk(3,4,5,6), pk(1,3,4,6), 29, 0));
        for (int b = 0; b < 5; b++) begin
            h = 10 + 4 * b;
            vt.push_back(mk(4'b1111, 4'b0000, 0, 1, 0, h, pk(h,h+1,h+2,h+3), 4'b0000, 0, 0, 25 - 4 * b, 0));
        end
        // Head wraps: reads 30,31,0,1.
        vt.push_back(mk(4'b1111, 4'b0000, 0, 1, 0, 30, pk(30,31,2,0), 4'b0000, 0, 0, 5, 0));
        for (int b = 0; b < 6; b++) begin
            e = 7 + 4 * b;
            vt.push_back(mk(4'b0000, 4'b1111, pk(e,e+1,e+2,e+3), 0, 0, 2, 0, 4'b1111,
                            pk(e,e+1,e+2,e+3), pk(e,e+1,e+2,e+3), 9 + 4 * b, 0));
        end
        // Tail wraps: sparse mask 1010 compacts to lanes 0,1 at addresses 31,0.
        vt.push_back(mk(4'b0000, 4'b1010, pk(0,0,0,2), 0, 0, 2, 0, 4'b0011, pk(31,0,0,0), pk(0,2,0,0), 31, 0));
        // Overflow: count 31 + 2 frees.
        vt.push_back(mk(4'b0000, 4'b0011, pk(31,31,0,0), 0, 0, 2, 0, 4'b0000, 0, 0, 31, 1));
        vt.push_back(mk(4'b1111, 4'b0000, 0, 1, 0, 2, pk(5,1,3,4), 4'b0000, 0, 0, 27, 1));
        vt.push_back(mk(4'b1111, 4'b0000, 0, 1, 0, 6, pk(6,7,8,9), 4'b0000, 0, 0, 23, 1));
        for (int b = 0; b < 5; b++) begin
            h = 10 + 4 * b;
            vt.push_back(mk(4'b1111, 4'b0000, 0, 1, 0, h, pk(h,h+1,h+2,h+3), 4'b0000, 0, 0, 19 - 4 * b, 1));
        end
        vt.push_back(mk(4'b0001, 4'b0000, 0, 1, 0, 30, pk(30,0,0,0), 4'b0000, 0, 0, 2, 1));
        // count=2 with 3 requested: stall, while same-cycle frees still land.
        vt.push_back(mk(4'b0111, 4'b0011, pk(5,1,0,0), 0, 1, 31, 0, 4'b0011, pk(1,2,0,0), pk(5,1,0,0), 4, 1));
        vt.push_back(mk(4'b0111, 4'b0000, 0, 1, 0, 31, pk(0,2,5,0), 4'b0000, 0, 0, 1, 1));
        vt.push_back(mk(4'b0011, 4'b0000, 0, 0, 1, 2, 0, 4'b0000, 0, 0, 1, 1));
        vt.push_back(mk(4'b0001, 4'b0000, 0, 1, 0, 2, pk(1,0,0,0), 4'b0000, 0, 0, 0, 1));
        vt.push_back(mk(4'b0001, 4'b0000, 0, 0, 1, 3, 0, 4'b0000, 0, 0, 0, 1));
        vt.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 3, 0, 4'b0000, 0, 0, 0, 1));

        // ---------------- reset and initial INIT ----------------
        reset = 1'b0; flush_i = 1'b0; dispatchReq_i = '0; freeVld_i = '0; freeEntry_i = '0;
        m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.wrEn", wrEn_o, 4'b0000);
        check("rst.grantVld", grantVld_o, 1'b0);
        check("rst.ready", ready_o, 1'b0);
        check("rst.freeCnt", freeCnt_o, 0);
        check("rst.error", error_o, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("init%0d.wrEn", i), wrEn_o, 4'b1111);
            check($sformatf("init%0d.wrAddr", i), wrAddr_o, pk(4*i, 4*i+1, 4*i+2, 4*i+3));
            check($sformatf("init%0d.wrData", i), wrData_o, pk(4*i, 4*i+1, 4*i+2, 4*i+3));
            check($sformatf("init%0d.stall", i), stall_o, 1'b1);
            check($sformatf("init%0d.ready", i), ready_o, 1'b0);
            @(posedge clk); #1;
            $display("init cycle %0d wrAddr=0x%05h", i, wrAddr_o);
        end
        check("post_init.ready", ready_o, 1'b1);
        check("post_init.freeCnt", freeCnt_o, 32);
        @(negedge clk);
        check("post_init.stall", stall_o, 1'b0);
        @(posedge clk); #1;
        model_reset_list();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vt.size(); i++) begin
            dispatchReq_i = vt[i].req;
            freeVld_i     = vt[i].fvld;
            freeEntry_i   = vt[i].fent;
            model_step(vt[i].req, vt[i].fvld, vt[i].fent, gv_d, st_d, idx_d, wren_d);
            @(negedge clk);
            check($sformatf("v%0d.grantVld", i), grantVld_o, vt[i].gv);
            check($sformatf("v%0d.stall", i), stall_o, vt[i].st);
            check($sformatf("v%0d.rdAddr", i), rdAddr_o, rdp(vt[i].head));
            if (vt[i].gv)
                check($sformatf("v%0d.grantIdx", i), grantIdx_o & lmask(vt[i].req), vt[i].idx & lmask(vt[i].req));
            check($sformatf("v%0d.wrEn", i), wrEn_o, vt[i].wren);
            if (vt[i].wren != 4'b0000) begin
                check($sformatf("v%0d.wrAddr", i), wrAddr_o & lmask(vt[i].wren), vt[i].wa & lmask(vt[i].wren));
                check($sformatf("v%0d.wrData", i), wrData_o & lmask(vt[i].wren), vt[i].wd & lmask(vt[i].wren));
            end
            @(posedge clk); #1;
            check($sformatf("v%0d.freeCnt", i), freeCnt_o, vt[i].cnt);
            check($sformatf("v%0d.error", i), error_o, vt[i].err);
            $display("vec %0d req=%b fvld=%b gv=%0d stall=%0d cnt=%0d err=%0d",
                     i, vt[i].req, vt[i].fvld, grantVld_o, stall_o, freeCnt_o, error_o);
        end

        // ---------------- flush in READY, then flush during INIT ----------------
        mcycle(4'b0000, 4'b1111, pk(0,1,2,3), "fl_pre0");
        mcycle(4'b0000, 4'b1111, pk(4,5,6,7), "fl_pre1");
        mcycle(4'b0000, 4'b0011, pk(8,9,0,0), "fl_pre2");
        check("fl.cnt10", freeCnt_o, 10);
        flush_i = 1'b1; dispatchReq_i = 4'b0001; freeVld_i = 4'b0001; freeEntry_i = pk(10,0,0,0);
        @(negedge clk);
        check("fl.grantVld", grantVld_o, 1'b0);
        check("fl.wrEn", wrEn_o, 4'b0000);
        check("fl.stall", stall_o, 1'b1);
        @(posedge clk); #1;
        check("fl.ready", ready_o, 1'b0);
        check("fl.freeCnt", freeCnt_o, 0);
        $display("flush in READY: ready=%0d cnt=%0d", ready_o, freeCnt_o);
        flush_i = 1'b0; dispatchReq_i = '0; freeVld_i = '0;
        for (int i = 0; i < 4; i++) begin
            flush_i = (i == 3);
            @(negedge clk);
            check($sformatf("fli%0d.wrEn", i), wrEn_o, 4'b1111);
            check($sformatf("fli%0d.wrAddr", i), wrAddr_o, pk(4*i, 4*i+1, 4*i+2, 4*i+3));
            @(posedge clk); #1;
            $display("flush init cycle %0d flush=%0d", i, flush_i);
        end
        flush_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rei%0d.wrAddr", i), wrAddr_o, pk(4*i, 4*i+1, 4*i+2, 4*i+3));
            check($sformatf("rei%0d.ready", i), ready_o, 1'b0);
            @(posedge clk); #1;
            $display("restart init cycle %0d", i);
        end
        check("rei.ready", ready_o, 1'b1);
        check("rei.freeCnt", freeCnt_o, 32);
        model_reset_list();
        mcycle(4'b0001, 4'b0000, 0, "fl_grant0");

        // ---------------- randomized traffic against the model ----------------
        for (int c = 0; c < 400; c++) begin
            int n, pick;
            int cand[$];
            logic [3:0]  req, fvld;
            logic [19:0] fent;
            n    = $urandom_range(0, 4);
            req  = 4'((1 << n) - 1);
            fvld = '0;
            fent = '0;
            cand.delete();
            for (int x = 0; x < DEPTH; x++) if (alloc_bits[x]) cand.push_back(x);
            for (int k = 0; k < 4; k++) begin
                if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                    pick = $urandom_range(0, cand.size() - 1);
                    fent[k*5 +: 5] = 5'(cand[pick]);
                    cand.delete(pick);
                    fvld[k] = 1'b1;
                end
            end
            mcycle(req, fvld, fent, $sformatf("rnd%0d", c));
        end

        // ---------------- reset clears the sticky error ----------------
        dispatchReq_i = '0; freeVld_i = '0;
        #2;
        reset = 1'b0;
        #1;
        check("rst2.error", error_o, 1'b0);
        check("rst2.ready", ready_o, 1'b0);
        check("rst2.wrEn", wrEn_o, 4'b0000);
        check("rst2.freeCnt", freeCnt_o, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst2.ready_after", ready_o, 1'b1);
        check("rst2.freeCnt_after", freeCnt_o, 32);
        $display("second reset done: ready=%0d cnt=%0d err=%0d", ready_o, freeCnt_o, error_o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
